// File: rtl/snic_net_pkg.sv
// rtl/snic_net_pkg.sv - shared types and constants for the net TX path
//
// Purpose: arbiter FSM state enum, AXIS dest tags and default stream widths
// used by the net TX arbiter and its skid slice.
package snic_net_pkg;

  localparam int NET_DATA_WIDTH = 512;
  localparam int NET_KEEP_WIDTH = NET_DATA_WIDTH / 8;

  // Source tag carried on m_axis_net_tx_dest
  localparam logic DEST_TCP = 1'b0;
  localparam logic DEST_BYP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_TCP = 2'd1,
    ST_GRANT_BYP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - 2-entry registered AXIS slice
//
// Purpose: fully registered stream slice; one cycle of latency, sustains one
// beat per cycle, absorbs the in-flight beat when downstream stalls.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_payload/s_valid   upstream beat, s_ready registered (high if <= 1 entry)
//   m_payload/m_valid   downstream beat, held stable until m_ready
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_payload,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_payload,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [1:0]       count;
  logic [1:0]       count_next;
  logic [WIDTH-1:0] head;   // entry presented downstream
  logic [WIDTH-1:0] spare;  // second entry, only used while stalled
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push      = s_valid & ready_q;
  assign pop       = m_valid & m_ready;
  assign m_valid   = (count != 2'd0);
  assign m_payload = head;
  assign s_ready   = ready_q;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      head    <= '0;
      spare   <= '0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
      // head only changes when empty or when the current head is popped,
      // which keeps the output stable under backpressure
      if (push && (count == 2'd0 || (pop && count == 2'd1))) begin
        head <= s_payload;
      end else if (pop) begin
        head <= spare;
      end
      if (push && !pop && count == 2'd1) begin
        spare <= s_payload;
      end
    end
  end

endmodule

// File: rtl/snic_net_tx_arbiter.sv
// rtl/snic_net_tx_arbiter.sv - packet-granular TCP/bypass net TX arbiter
//
// Purpose: shares the net TX AXIS port between the TCP stack and the bypass
// path, round-robin at packet boundaries, tagging each beat with its source.
// Ports:
//   clk_250mhz, clk_250mhz_rst     clock, synchronous active-high reset
//   s_axis_tcp_tx_*                TCP stack input stream
//   s_axis_byp_tx_*                bypass/handler input stream
//   m_axis_net_tx_*                merged output stream, dest = source tag
//   stat_tcp_pkts, stat_byp_pkts   completed packets accepted per source
//   busy                           a grant is in progress
module snic_net_tx_arbiter
  import snic_net_pkg::*;
#(
  parameter int DATA_WIDTH = NET_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_250mhz,
  input  logic                  clk_250mhz_rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tcp_tx_data,
  input  logic [KEEP_WIDTH-1:0] s_axis_tcp_tx_keep,
  input  logic                  s_axis_tcp_tx_last,
  input  logic                  s_axis_tcp_tx_valid,
  output logic                  s_axis_tcp_tx_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_byp_tx_data,
  input  logic [KEEP_WIDTH-1:0] s_axis_byp_tx_keep,
  input  logic                  s_axis_byp_tx_last,
  input  logic                  s_axis_byp_tx_valid,
  output logic                  s_axis_byp_tx_ready,
  output logic [DATA_WIDTH-1:0] m_axis_net_tx_data,
  output logic [KEEP_WIDTH-1:0] m_axis_net_tx_keep,
  output logic                  m_axis_net_tx_last,
  output logic                  m_axis_net_tx_dest,
  output logic                  m_axis_net_tx_valid,
  input  logic                  m_axis_net_tx_ready,
  output logic [31:0]           stat_tcp_pkts,
  output logic [31:0]           stat_byp_pkts,
  output logic                  busy
);

  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 2;

  arb_state_t    state;
  logic          last_grant;
  logic          skid_ready;
  logic          skid_valid;
  logic [PW-1:0] skid_in;
  logic [PW-1:0] skid_out;
  logic          tcp_fire;
  logic          byp_fire;

  // Only the granted input sees the slice ready; dest comes from the state
  always_comb begin
    s_axis_tcp_tx_ready = 1'b0;
    s_axis_byp_tx_ready = 1'b0;
    skid_valid          = 1'b0;
    skid_in = {s_axis_tcp_tx_data, s_axis_tcp_tx_keep, s_axis_tcp_tx_last, DEST_TCP};
    case (state)
      ST_GRANT_TCP: begin
        s_axis_tcp_tx_ready = skid_ready;
        skid_valid          = s_axis_tcp_tx_valid;
      end
      ST_GRANT_BYP: begin
        s_axis_byp_tx_ready = skid_ready;
        skid_valid          = s_axis_byp_tx_valid;
        skid_in = {s_axis_byp_tx_data, s_axis_byp_tx_keep, s_axis_byp_tx_last, DEST_BYP};
      end
      default: ;
    endcase
  end

  assign tcp_fire = s_axis_tcp_tx_valid & s_axis_tcp_tx_ready;
  assign byp_fire = s_axis_byp_tx_valid & s_axis_byp_tx_ready;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk_250mhz) begin
    if (clk_250mhz_rst) begin
      state         <= ST_IDLE;
      last_grant    <= DEST_BYP;  // TCP wins the first tie
      stat_tcp_pkts <= 32'd0;
      stat_byp_pkts <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_axis_tcp_tx_valid && (!s_axis_byp_tx_valid || last_grant == DEST_BYP)) begin
            state      <= ST_GRANT_TCP;
            last_grant <= DEST_TCP;
          end else if (s_axis_byp_tx_valid) begin
            state      <= ST_GRANT_BYP;
            last_grant <= DEST_BYP;
          end
        end
        ST_GRANT_TCP: begin
          if (tcp_fire && s_axis_tcp_tx_last) begin
            state         <= ST_IDLE;
            stat_tcp_pkts <= stat_tcp_pkts + 32'd1;
          end
        end
        ST_GRANT_BYP: begin
          if (byp_fire && s_axis_byp_tx_last) begin
            state         <= ST_IDLE;
            stat_byp_pkts <= stat_byp_pkts + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_reg #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk_250mhz),
    .rst      (clk_250mhz_rst),
    .s_payload(skid_in),
    .s_valid  (skid_valid),
    .s_ready  (skid_ready),
    .m_payload(skid_out),
    .m_valid  (m_axis_net_tx_valid),
    .m_ready  (m_axis_net_tx_ready)
  );

  assign {m_axis_net_tx_data, m_axis_net_tx_keep, m_axis_net_tx_last, m_axis_net_tx_dest} = skid_out;

endmodule

// File: tb/tb_snic_net_tx_arbiter.sv
// tb/tb_snic_net_tx_arbiter.sv - self-checking bench for snic_net_tx_arbiter
module tb_snic_net_tx_arbiter;

  localparam int DW = 512;
  localparam int KW = 64;

  typedef struct {
    logic          gap;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } in_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          dest;
    int            cyc;
  } out_t;

  typedef struct {
    logic          src;
    int            len;
    logic [31:0]   tag;
    logic [KW-1:0] keep;
    logic          exp_dest;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tcp_data = '0;
  logic [KW-1:0] tcp_keep = '0;
  logic          tcp_last = 1'b0;
  logic          tcp_valid = 1'b0;
  wire           tcp_ready;
  logic [DW-1:0] byp_data = '0;
  logic [KW-1:0] byp_keep = '0;
  logic          byp_last = 1'b0;
  logic          byp_valid = 1'b0;
  wire           byp_ready;
  wire  [DW-1:0] m_data;
  wire  [KW-1:0] m_keep;
  wire           m_last;
  wire           m_dest;
  wire           m_valid;
  logic          m_ready = 1'b1;
  wire  [31:0]   stat_tcp;
  wire  [31:0]   stat_byp;
  wire           busy;

  snic_net_tx_arbiter dut (
    .clk_250mhz         (clk),
    .clk_250mhz_rst     (rst),
    .s_axis_tcp_tx_data (tcp_data),
    .s_axis_tcp_tx_keep (tcp_keep),
    .s_axis_tcp_tx_last (tcp_last),
    .s_axis_tcp_tx_valid(tcp_valid),
    .s_axis_tcp_tx_ready(tcp_ready),
    .s_axis_byp_tx_data (byp_data),
    .s_axis_byp_tx_keep (byp_keep),
    .s_axis_byp_tx_last (byp_last),
    .s_axis_byp_tx_valid(byp_valid),
    .s_axis_byp_tx_ready(byp_ready),
    .m_axis_net_tx_data (m_data),
    .m_axis_net_tx_keep (m_keep),
    .m_axis_net_tx_last (m_last),
    .m_axis_net_tx_dest (m_dest),
    .m_axis_net_tx_valid(m_valid),
    .m_axis_net_tx_ready(m_ready),
    .stat_tcp_pkts      (stat_tcp),
    .stat_byp_pkts      (stat_byp),
    .busy               (busy)
  );

  in_t  tcp_q[$];
  in_t  byp_q[$];
  out_t out_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   tcp_fire_n = 0, byp_fire_n = 0;
  bit   bp_mode = 0, stab_en = 0, watch_tcp = 0;
  int   stab_viol = 0, stall_cnt = 0, tcp_rdy_viol = 0;
  bit   prev_stall = 0;
  out_t prev_beat;

  initial forever #2 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1);
  end

  // Downstream ready: toggles every cycle in backpressure mode
  initial forever begin
    @(posedge clk); #1;
    if (bp_mode) m_ready = ~m_ready;
    else         m_ready = 1'b1;
  end

  // Source feeders: a gap entry drives valid low for one cycle
  initial begin : feed_tcp
    bit gap_shown;
    gap_shown = 0;
    forever begin
      @(posedge clk); #1;
      if ((tcp_fire_n || gap_shown) && tcp_q.size() > 0) void'(tcp_q.pop_front());
      gap_shown = 0;
      if (tcp_q.size() > 0 && tcp_q[0].gap) begin
        tcp_valid = 1'b0;
        gap_shown = 1;
      end else if (tcp_q.size() > 0) begin
        tcp_valid = 1'b1;
        tcp_data  = tcp_q[0].data;
        tcp_keep  = tcp_q[0].keep;
        tcp_last  = tcp_q[0].last;
      end else begin
        tcp_valid = 1'b0;
      end
    end
  end

  initial begin : feed_byp
    bit gap_shown;
    gap_shown = 0;
    forever begin
      @(posedge clk); #1;
      if ((byp_fire_n || gap_shown) && byp_q.size() > 0) void'(byp_q.pop_front());
      gap_shown = 0;
      if (byp_q.size() > 0 && byp_q[0].gap) begin
        byp_valid = 1'b0;
        gap_shown = 1;
      end else if (byp_q.size() > 0) begin
        byp_valid = 1'b1;
        byp_data  = byp_q[0].data;
        byp_keep  = byp_q[0].keep;
        byp_last  = byp_q[0].last;
      end else begin
        byp_valid = 1'b0;
      end
    end
  end

  // Output monitor: records transfers, checks stability while stalled
  always @(negedge clk) begin
    tcp_fire_n = tcp_valid & tcp_ready;
    byp_fire_n = byp_valid & byp_ready;
    if (m_valid && m_ready) out_q.push_back('{m_data, m_keep, m_last, m_dest, cyc});
    if (stab_en && prev_stall &&
        (m_valid !== 1'b1 || m_data !== prev_beat.data || m_keep !== prev_beat.keep ||
         m_last !== prev_beat.last || m_dest !== prev_beat.dest))
      stab_viol++;
    if (stab_en && m_valid && !m_ready) stall_cnt++;
    if (watch_tcp && tcp_ready) tcp_rdy_viol++;
    prev_stall = m_valid & ~m_ready;
    prev_beat  = '{m_data, m_keep, m_last, m_dest, cyc};
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(logic [31:0] tag);
    return {16{tag}};
  endfunction

  task automatic push_beat(logic src, logic [31:0] tag, logic [KW-1:0] keep, logic last);
    in_t b;
    b.gap  = 1'b0;
    b.data = mk_data(tag);
    b.keep = keep;
    b.last = last;
    if (src) byp_q.push_back(b);
    else     tcp_q.push_back(b);
  endtask

  task automatic push_gap(logic src, int n);
    in_t b;
    b.gap  = 1'b1;
    b.data = '0;
    b.keep = '0;
    b.last = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (src) byp_q.push_back(b);
      else     tcp_q.push_back(b);
    end
  endtask

  task automatic push_pkt(logic src, int len, logic [31:0] tag, logic [KW-1:0] keep);
    for (int i = 0; i < len; i++) push_beat(src, tag + 32'(i), keep, (i == len - 1));
  endtask

  task automatic wait_out(int n, int budget, string name);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (out_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout: actual %0d beats required %0d", name, out_q.size(), n);
    end
  endtask

  task automatic chk_beat(string name, int idx, logic [31:0] tag, logic [KW-1:0] keep,
                          logic last, logic dest);
    checks++;
    if (idx >= out_q.size()) begin
      errors++;
      $display("FAIL %s beat %0d: actual missing required data 0x%0h", name, idx, tag);
    end else if (out_q[idx].data !== mk_data(tag) || out_q[idx].keep !== keep ||
                 out_q[idx].last !== last || out_q[idx].dest !== dest) begin
      errors++;
      $display("FAIL %s beat %0d: actual data=0x%0h keep=0x%0h last=%0b dest=%0b required data=0x%0h keep=0x%0h last=%0b dest=%0b",
               name, idx, out_q[idx].data[31:0], out_q[idx].keep, out_q[idx].last,
               out_q[idx].dest, tag, keep, last, dest);
    end
  endtask

  task automatic do_reset();
    tcp_q.delete();
    byp_q.delete();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    out_q.delete();
  endtask

  initial begin : main
    vec_t        vecs[4];
    int          c0;
    logic [31:0] exp_tcp, exp_byp;
    logic [KW-1:0] ones;
    string       nm;

    ones    = {KW{1'b1}};
    vecs[0] = '{1'b0, 3, 32'h1000_0000, {KW{1'b1}}, 1'b0};
    vecs[1] = '{1'b1, 1, 32'h2000_0000, 64'h0000_0000_0000_00FF, 1'b1};
    vecs[2] = '{1'b1, 4, 32'h3000_0000, 64'h0, 1'b1};
    vecs[3] = '{1'b0, 2, 32'h4000_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_tcp_ready", 32'(tcp_ready), 32'd0);
    check("rst_byp_ready", 32'(byp_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stat_tcp", stat_tcp, 32'd0);
    check("rst_stat_byp", stat_byp, 32'd0);
    check("rst_data_nonzero", 32'(|m_data), 32'd0);
    check("rst_keep_last_dest", {m_keep[31:0] | m_keep[63:32]} | 32'(m_last) | 32'(m_dest), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Table-driven single packets from idle
    exp_tcp = 0;
    exp_byp = 0;
    for (int v = 0; v < 4; v++) begin
      nm = $sformatf("vec%0d", v);
      out_q.delete();
      c0 = cyc;
      push_pkt(vecs[v].src, vecs[v].len, vecs[v].tag, vecs[v].keep);
      wait_out(vecs[v].len, 40, nm);
      for (int b = 0; b < vecs[v].len; b++)
        chk_beat(nm, b, vecs[v].tag + 32'(b), vecs[v].keep, (b == vecs[v].len - 1), vecs[v].exp_dest);
      if (out_q.size() > 0) check({nm, "_latency"}, 32'(out_q[0].cyc - c0), 32'd3);
      repeat (3) tick();
      if (vecs[v].src) exp_byp = exp_byp + 1;
      else             exp_tcp = exp_tcp + 1;
      check({nm, "_stat_tcp"}, stat_tcp, exp_tcp);
      check({nm, "_stat_byp"}, stat_byp, exp_byp);
      check({nm, "_busy_after"}, 32'(busy), 32'd0);
      check({nm, "_extra_beats"}, 32'(out_q.size()), 32'(vecs[v].len));
    end

    // Simultaneous first request after reset: TCP first, one bubble
    do_reset();
    push_pkt(1'b1, 2, 32'h5100_0000, ones);
    push_pkt(1'b0, 2, 32'h5000_0000, ones);
    wait_out(4, 60, "simul");
    chk_beat("simul", 0, 32'h5000_0000, ones, 1'b0, 1'b0);
    chk_beat("simul", 1, 32'h5000_0001, ones, 1'b1, 1'b0);
    chk_beat("simul", 2, 32'h5100_0000, ones, 1'b0, 1'b1);
    chk_beat("simul", 3, 32'h5100_0001, ones, 1'b1, 1'b1);
    if (out_q.size() >= 3) check("simul_bubble", 32'(out_q[2].cyc - out_q[1].cyc), 32'd2);
    repeat (3) tick();
    check("simul_stat_tcp", stat_tcp, 32'd1);
    check("simul_stat_byp", stat_byp, 32'd1);

    // Fairness under saturation: strict alternation of 1-beat packets
    out_q.delete();
    for (int i = 0; i < 10; i++) begin
      push_pkt(1'b0, 1, 32'h6000_0000 + 32'(2 * i), ones);
      push_pkt(1'b1, 1, 32'h6000_0000 + 32'(2 * i + 1), ones);
    end
    wait_out(20, 200, "fair");
    for (int i = 0; i < 20; i++)
      chk_beat("fair", i, 32'h6000_0000 + 32'(i), ones, 1'b1, 1'(i % 2));
    repeat (3) tick();
    check("fair_stat_tcp", stat_tcp, 32'd11);
    check("fair_stat_byp", stat_byp, 32'd11);

    // Backpressure on an 8-beat bypass packet
    out_q.delete();
    stab_en   = 1;
    watch_tcp = 1;
    bp_mode   = 1;
    push_pkt(1'b1, 8, 32'h7000_0000, ones);
    wait_out(8, 100, "bp");
    repeat (4) tick();
    bp_mode   = 0;
    stab_en   = 0;
    watch_tcp = 0;
    for (int b = 0; b < 8; b++) chk_beat("bp", b, 32'h7000_0000 + 32'(b), ones, (b == 7), 1'b1);
    check("bp_beat_count", 32'(out_q.size()), 32'd8);
    check("bp_stability_violations", 32'(stab_viol), 32'd0);
    check("bp_stall_seen", 32'(stall_cnt > 0), 32'd1);
    check("bp_tcp_ready_violations", 32'(tcp_rdy_viol), 32'd0);
    check("bp_stat_byp", stat_byp, 32'd12);

    // Mid-packet valid gap: grant held, bypass served after TCP last
    out_q.delete();
    push_beat(1'b0, 32'h8000_0000, ones, 1'b0);
    push_gap(1'b0, 5);
    push_beat(1'b0, 32'h8000_0001, ones, 1'b0);
    push_beat(1'b0, 32'h8000_0002, ones, 1'b1);
    push_pkt(1'b1, 1, 32'h8100_0000, ones);
    wait_out(4, 80, "gap");
    chk_beat("gap", 0, 32'h8000_0000, ones, 1'b0, 1'b0);
    chk_beat("gap", 1, 32'h8000_0001, ones, 1'b0, 1'b0);
    chk_beat("gap", 2, 32'h8000_0002, ones, 1'b1, 1'b0);
    chk_beat("gap", 3, 32'h8100_0000, ones, 1'b1, 1'b1);
    if (out_q.size() >= 2) check("gap_spacing", 32'(out_q[1].cyc - out_q[0].cyc), 32'd6);
    repeat (3) tick();
    check("gap_stat_tcp", stat_tcp, 32'd12);
    check("gap_stat_byp", stat_byp, 32'd13);

    // Reset pulsed mid-packet
    out_q.delete();
    push_pkt(1'b0, 4, 32'h9000_0000, ones);
    wait_out(2, 40, "midrst_pre");
    rst = 1'b1;
    tcp_q.delete();
    byp_q.delete();
    tick();
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_tcp_ready", 32'(tcp_ready), 32'd0);
    check("midrst_byp_ready", 32'(byp_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_stat_tcp", stat_tcp, 32'd0);
    check("midrst_stat_byp", stat_byp, 32'd0);
    rst = 1'b0;
    tick();
    out_q.delete();
    push_pkt(1'b1, 1, 32'hA100_0000, ones);
    push_pkt(1'b0, 1, 32'hA000_0000, ones);
    wait_out(2, 40, "midrst_post");
    chk_beat("midrst_post", 0, 32'hA000_0000, ones, 1'b1, 1'b0);
    chk_beat("midrst_post", 1, 32'hA100_0000, ones, 1'b1, 1'b1);
    repeat (3) tick();
    check("midrst_post_stat_tcp", stat_tcp, 32'd1);
    check("midrst_post_stat_byp", stat_byp, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snic_net_tx_arbiter.md
# snic_net_tx_arbiter

Packet-granular two-input arbiter that shares the single 512-bit network TX AXI-Stream port between the TCP stack output and the bypass/handler output. Sits between the TCP offload engine and the MAC-side net TX interface. Round-robin fairness is applied at packet boundaries only. Each output packet is tagged with its source on `dest`, and per-source packet counts are kept for debug.

## Interface
Parameters:
- `DATA_WIDTH`, 512, AXIS data width in bits.
- `KEEP_WIDTH`, `DATA_WIDTH/8`, byte-enable width.

Ports:
- `clk_250mhz`  in  1  Single clock for the block.
- `clk_250mhz_rst`  in  1  Synchronous, active-high reset.
- `s_axis_tcp_tx_data`  in  DATA_WIDTH  TCP stack beat data.
- `s_axis_tcp_tx_keep`  in  KEEP_WIDTH  TCP beat byte enables.
- `s_axis_tcp_tx_last`  in  1  TCP end of packet.
- `s_axis_tcp_tx_valid`  in  1  TCP beat valid.
- `s_axis_tcp_tx_ready`  out  1  TCP beat accepted.
- `s_axis_byp_tx_data`  in  DATA_WIDTH  Bypass beat data.
- `s_axis_byp_tx_keep`  in  KEEP_WIDTH  Bypass byte enables.
- `s_axis_byp_tx_last`  in  1  Bypass end of packet.
- `s_axis_byp_tx_valid`  in  1  Bypass beat valid.
- `s_axis_byp_tx_ready`  out  1  Bypass beat accepted.
- `m_axis_net_tx_data`  out  DATA_WIDTH  Merged beat data.
- `m_axis_net_tx_keep`  out  KEEP_WIDTH  Merged byte enables.
- `m_axis_net_tx_last`  out  1  Merged end of packet.
- `m_axis_net_tx_dest`  out  1  Source tag: 0 = TCP, 1 = bypass.
- `m_axis_net_tx_valid`  out  1  Merged beat valid.
- `m_axis_net_tx_ready`  in  1  Downstream ready.
- `stat_tcp_pkts`  out  32  Completed TCP packets accepted.
- `stat_byp_pkts`  out  32  Completed bypass packets accepted.
- `busy`  out  1  High in GRANT_TCP or GRANT_BYP.

## Operation
- FSM states: IDLE, GRANT_TCP, GRANT_BYP.
- IDLE transitions:
  - Only TCP valid -> GRANT_TCP.
  - Only bypass valid -> GRANT_BYP.
  - Both valid -> grant the source opposite `last_grant`.
  - Neither valid -> stay in IDLE.
  - `last_grant` is updated on entry to a GRANT state.
- GRANT_x behaviour:
  - `s_axis_x_ready` = skid-buffer `s_ready`; the other input's ready is held at 0.
  - A beat is accepted when valid and ready are both high at the input.
  - Acceptance of a beat with `last` = 1 returns the FSM to IDLE and increments `stat_x_pkts`.
- No preemption and no timeout. If the granted input drops valid mid-packet, the grant is held indefinitely.
- `data`, `keep` and `last` pass through unmodified. A beat with `keep` = 0 is forwarded as-is.
- `dest` is the registered grant, captured with each beat into the skid buffer.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.

## Timing
- Arbitration decision takes one cycle in IDLE. Input ready rises the cycle after IDLE sees valid.
- Input-to-output latency is 1 cycle: a beat accepted in cycle N is presented on the output in cycle N+1.
- There is one bubble cycle (IDLE) between consecutive packets. Peak throughput is (L/(L+1)) beats/cycle for L-beat packets.
- The output follows AXIS rules: once `m_axis_net_tx_valid` is high, valid, data, keep, last and dest stay stable until ready.
- Skid buffer behaviour:
  - 2 entries.
  - `s_ready` is registered, high when at most 1 entry is occupied.
  - Sustains 1 beat/cycle with ready held high.
  - Under downstream backpressure it absorbs the in-flight beat without loss.
- Simultaneous events:
  - Accepting an input `last` and popping an output beat in the same cycle is legal.
  - The FSM still spends one cycle in IDLE before the next grant.
- Reset values:
  - All ready and valid outputs are 0, and `busy` is 0.
  - Counters are 0.
  - FSM is in IDLE.
  - `last_grant` = bypass, so TCP wins the first tie.
  - The skid buffer is emptied.
  - `m_axis_net_tx_data`, `keep`, `last` and `dest` are 0.
- Reset asserted mid-packet drops the partial packet. Recovery from a truncated output packet is the downstream's responsibility.

## Structure
- Shared package `snic_net_pkg` holds:
  - The grant/FSM state enum (IDLE, GRANT_TCP, GRANT_BYP).
  - Dest constants `DEST_TCP` = 0 and `DEST_BYP` = 1.
  - The default widths 512/64.
- Sub-module `axis_skid_reg`:
  - A 2-entry registered AXIS slice, parameterized on payload width.
  - Payload = data + keep + last + dest.
  - Reusable elsewhere on the net path.
- Top level contains the FSM, the input muxing and the counters.

## Test plan
- **Single TCP packet.** 3-beat TCP packet, ready held at 1 -> 3 output beats with `dest` = 0, `last` only on beat 3, first beat 2 cycles after valid, `stat_tcp_pkts` = 1.
- **Simultaneous first request.** Both inputs present 2-beat packets in the same cycle after reset:
  - Order is TCP then bypass, with one bubble between packets.
  - No interleaving of beats.
  - Both counters = 1.
- **Fairness under saturation.** Both inputs continuously valid with 1-beat packets for 20 packets -> strict alternation with `dest` 0,1,0,1,…, and each counter = 10.
- **Backpressure.** `m_axis_net_tx_ready` toggled 1/0 every cycle during an 8-beat bypass packet:
  - No beat is lost or duplicated.
  - Data order is preserved.
  - Output stays stable while ready is 0.
  - The TCP input's ready stays 0 throughout.
- **Mid-packet valid gap.** The granted input deasserts valid for 5 cycles mid-packet while the other input is valid -> the grant is held, and the other input is served only after the first packet's `last`.
- **Reset mid-packet.** `clk_250mhz_rst` pulsed for 1 cycle at beat 2 of a 4-beat packet:
  - The next cycle, all valid and ready outputs are 0 and counters are 0.
  - The next packet is arbitrated from IDLE with TCP priority.
